// File: rtl/mem_rd_arb_pkg.sv
// Shared constants and types for the data-memory read-port arbiter.
// Default sizes, the address type and the per-cycle lookup outcome.
package mem_pkg;

  localparam int N_DEF       = 3;
  localparam int AW_DEF      = 16;
  localparam int MAX_OUT_DEF = 4;

  typedef logic [AW_DEF-1:0] maddr_t;

  typedef enum logic [1:0] {
    LK_IDLE,
    LK_MERGE,
    LK_ISSUE,
    LK_STALL
  } lookup_e;

endpackage

// File: rtl/mem_rd_arb_if.sv
// Requester/memory-side bundle of the read-port arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface mem_rd_arb_if #(
  parameter int N       = mem_pkg::N_DEF,
  parameter int AW      = mem_pkg::AW_DEF,
  parameter int MAX_OUT = mem_pkg::MAX_OUT_DEF
);

  localparam int CW = $clog2(MAX_OUT) + 1;

  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_gnt;
  logic            mem_re;
  logic [AW-1:0]   mem_raddr;
  logic            mem_ready;
  logic [AW-1:0]   mem_addr_out;
  logic [CW-1:0]   out_cnt;
  logic            busy;

  modport master (
    output req_valid, req_addr, mem_ready, mem_addr_out,
    input  req_gnt, mem_re, mem_raddr, out_cnt, busy
  );

  modport slave (
    input  req_valid, req_addr, mem_ready, mem_addr_out,
    output req_gnt, mem_re, mem_raddr, out_cnt, busy
  );

endinterface

// File: rtl/mem_rd_arb_rr_pick.sv
// Round-robin find-first: the first set request above ptr, wrapping around.
// Purely combinational; returns the winner both one-hot and as an index.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin : scan
    int j;
    gnt_oh = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found     = 1'b1;
        gnt_oh[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_rd_arb.sv
// Shares one long-latency memory read port among N requesters, merging
// requests to addresses already in flight via a small outstanding table.
module mem_rd_arb
  import mem_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int AW      = AW_DEF
) (
  input logic         clk,
  input logic         rst_n,
  mem_rd_arb_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT) + 1;

  logic [MAX_OUT-1:0] ent_valid;
  logic [AW-1:0]      ent_addr [MAX_OUT];
  logic [IW-1:0]      ptr;
  logic               mem_re_q;
  logic [AW-1:0]      mem_raddr_q;

  logic [N-1:0]       pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic [AW-1:0]      cand_addr;
  logic [MAX_OUT-1:0] ret_hit;
  logic [MAX_OUT-1:0] cam_hit;
  logic [FW-1:0]      free_idx;
  logic               free_found;
  lookup_e            lookup;
  logic [N-1:0]       grant_oh;
  logic               alloc;
  logic [MAX_OUT-1:0] valid_nxt;
  logic [CW-1:0]      cnt;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .gnt_oh (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign cand_addr = bus.req_addr[int'(pick_idx)*AW +: AW];

  // An entry retiring this cycle can't serve a merge: its requester would miss
  // the broadcast. It also stays occupied until the edge, so isn't free yet.
  always_comb begin
    ret_hit    = '0;
    cam_hit    = '0;
    free_idx   = '0;
    free_found = 1'b0;
    for (int e = 0; e < MAX_OUT; e++) begin
      ret_hit[e] = bus.mem_ready && ent_valid[e] && (ent_addr[e] == bus.mem_addr_out);
      cam_hit[e] = ent_valid[e] && (ent_addr[e] == cand_addr) && !ret_hit[e];
      if (!free_found && !ent_valid[e]) begin
        free_found = 1'b1;
        free_idx   = FW'(e);
      end
    end
  end

  always_comb begin
    lookup = LK_IDLE;
    if (rst_n && pick_found) begin
      if (|cam_hit)        lookup = LK_MERGE;
      else if (free_found) lookup = LK_ISSUE;
      else                 lookup = LK_STALL;
    end
    grant_oh  = (lookup == LK_MERGE || lookup == LK_ISSUE) ? pick_oh : '0;
    alloc     = (lookup == LK_ISSUE);
    valid_nxt = ent_valid & ~ret_hit;
    if (alloc) valid_nxt[free_idx] = 1'b1;
  end

  always_comb begin
    cnt = '0;
    for (int e = 0; e < MAX_OUT; e++) cnt = cnt + CW'(ent_valid[e]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid   <= '0;
      for (int e = 0; e < MAX_OUT; e++) ent_addr[e] <= '0;
      ptr         <= IW'(N - 1);
      mem_re_q    <= 1'b0;
      mem_raddr_q <= '0;
    end else begin
      ent_valid <= valid_nxt;
      if (alloc) ent_addr[free_idx] <= cand_addr;
      if (|grant_oh) ptr <= pick_idx;
      mem_re_q    <= alloc;
      mem_raddr_q <= alloc ? cand_addr : '0;
    end
  end

  assign bus.req_gnt   = grant_oh;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_raddr = mem_raddr_q;
  assign bus.out_cnt   = cnt;
  assign bus.busy      = (cnt != '0) || mem_re_q;

endmodule
